// File: rtl/ext_rom_pkg.sv
// Shared widths and port-A owner encoding for the extension ROM arbiter.
package ext_rom_pkg;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_CPU   = 2'd1,
    OWN_LD_RD = 2'd2,
    OWN_LD_WR = 2'd3
  } own_t;
endpackage

// File: rtl/ext_rom_starve_ctr.sv
// Saturating count of CPU wins while the loader waits; o_force grants the loader the next slot.
module ext_rom_starve_ctr
  import ext_rom_pkg::*;
#(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ld_req,
  input  logic i_ld_waiting,
  input  logic i_cpu_issue,
  input  logic i_ld_issue,
  output logic o_force
);
  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] C_LIMIT = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_ld_issue || !i_ld_req) begin
      r_cnt <= '0;
    end else if (i_cpu_issue && i_ld_waiting && (r_cnt != C_LIMIT)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_force = (r_cnt == C_LIMIT);
endmodule

// File: rtl/ext_rom_arbiter.sv
// Port-A arbiter for the extension ROM RAM: CPU reads first, loader via req/ack with starvation relief.
// Optional write protection of loader writes is built when EXT_ROM_WP_EN is defined.
module ext_rom_arbiter
  import ext_rom_pkg::*;
#(
  parameter int ADDR_W       = ext_rom_pkg::ADDR_W,
  parameter int DATA_W       = ext_rom_pkg::DATA_W,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cpu_req,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  output logic              o_cpu_wait,
  output logic              o_cpu_valid,
  output logic [DATA_W-1:0] o_cpu_data,
  input  logic              i_ld_req,
  input  logic              i_ld_we,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [DATA_W-1:0] i_ld_wdata,
  output logic              o_ld_ack,
  output logic [DATA_W-1:0] o_ld_rdata,
  input  logic              i_wp,
  output logic              o_ld_err,
  output logic              o_mem_cea,
  output logic              o_mem_ocea,
  output logic              o_mem_reseta,
  output logic              o_mem_wrea,
  output logic [ADDR_W-1:0] o_mem_ada,
  output logic [DATA_W-1:0] o_mem_dina,
  input  logic [DATA_W-1:0] i_mem_douta
);
  own_t              r_own;
  logic              r_cpu_pend;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_cpu_data;
  logic [DATA_W-1:0] r_ld_rdata;
  logic              r_ld_err;

  logic w_ld_inflight, w_ld_elig, w_force;
  logic w_iss_pend, w_iss_force, w_iss_cpu, w_iss_ld, w_cpu_issue;
  logic w_wp_block, w_wr_ok;

`ifdef EXT_ROM_WP_EN
  assign w_wp_block = i_ld_we && i_wp;
`else
  logic w_unused_wp;
  assign w_unused_wp = i_wp;
  assign w_wp_block  = 1'b0;
`endif
  assign w_wr_ok = i_ld_we && !w_wp_block;

  // Gating with rst_n keeps the RAM port quiet while reset is asserted.
  assign w_ld_inflight = (r_own == OWN_LD_RD) || (r_own == OWN_LD_WR);
  assign w_ld_elig     = rst_n && i_ld_req && !w_ld_inflight;
  assign w_iss_pend    = rst_n && r_cpu_pend;
  assign w_iss_force   = !r_cpu_pend && w_force && w_ld_elig;
  assign w_iss_cpu     = rst_n && !r_cpu_pend && !w_iss_force && i_cpu_req;
  assign w_iss_ld      = !r_cpu_pend && !w_iss_cpu && w_ld_elig;
  assign w_cpu_issue   = w_iss_pend || w_iss_cpu;

  ext_rom_starve_ctr #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ld_req     (i_ld_req),
    .i_ld_waiting (w_ld_elig),
    .i_cpu_issue  (w_cpu_issue),
    .i_ld_issue   (w_iss_ld),
    .o_force      (w_force)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own       <= OWN_NONE;
      r_cpu_pend  <= 1'b0;
      r_pend_addr <= '0;
      r_cpu_data  <= '0;
      r_ld_rdata  <= '0;
      r_ld_err    <= 1'b0;
    end else begin
      if (w_cpu_issue) begin
        r_own <= OWN_CPU;
      end else if (w_iss_ld) begin
        r_own <= i_ld_we ? OWN_LD_WR : OWN_LD_RD;
      end else begin
        r_own <= OWN_NONE;
      end
      // A strobe that loses to a forced loader slot is replayed next cycle.
      if (w_iss_force && i_cpu_req) begin
        r_cpu_pend  <= 1'b1;
        r_pend_addr <= i_cpu_addr;
      end else if (w_iss_pend) begin
        r_cpu_pend <= 1'b0;
      end
      if (r_own == OWN_CPU)   r_cpu_data <= i_mem_douta;
      if (r_own == OWN_LD_RD) r_ld_rdata <= i_mem_douta;
      if (w_iss_ld && w_wp_block) r_ld_err <= 1'b1;
    end
  end

  assign o_mem_cea    = w_cpu_issue || w_iss_ld;
  assign o_mem_wrea   = w_iss_ld && w_wr_ok;
  assign o_mem_ada    = w_iss_pend ? r_pend_addr :
                        w_iss_cpu  ? i_cpu_addr  :
                        w_iss_ld   ? i_ld_addr   : '0;
  assign o_mem_dina   = w_iss_ld ? i_ld_wdata : '0;
  assign o_mem_ocea   = 1'b1;
  assign o_mem_reseta = 1'b0;

  assign o_cpu_wait  = r_cpu_pend;
  assign o_cpu_valid = (r_own == OWN_CPU);
  assign o_cpu_data  = o_cpu_valid ? i_mem_douta : r_cpu_data;
  assign o_ld_ack    = w_ld_inflight;
  assign o_ld_rdata  = (r_own == OWN_LD_RD) ? i_mem_douta : r_ld_rdata;
  assign o_ld_err    = r_ld_err;
endmodule

// File: tb/tb_ext_rom_arbiter.sv
// Bench for ext_rom_arbiter: directed scenarios then random traffic against a cycle-level reference model.
module tb_ext_rom_arbiter;
  localparam int STARVE = 8;
`ifdef EXT_ROM_WP_EN
  localparam bit WP_EN = 1'b1;
`else
  localparam bit WP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, ld_req, ld_we, wp;
  logic [10:0] cpu_addr, ld_addr;
  logic [7:0]  ld_wdata;
  logic        cpu_wait, cpu_valid, ld_ack, ld_err;
  logic [7:0]  cpu_data, ld_rdata;
  logic        mem_cea, mem_ocea, mem_reseta, mem_wrea;
  logic [10:0] mem_ada;
  logic [7:0]  mem_dina, mem_douta;

  always #5 clk = ~clk;

  ext_rom_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_addr(cpu_addr), .o_cpu_wait(cpu_wait),
    .o_cpu_valid(cpu_valid), .o_cpu_data(cpu_data),
    .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr), .i_ld_wdata(ld_wdata),
    .o_ld_ack(ld_ack), .o_ld_rdata(ld_rdata), .i_wp(wp), .o_ld_err(ld_err),
    .o_mem_cea(mem_cea), .o_mem_ocea(mem_ocea), .o_mem_reseta(mem_reseta),
    .o_mem_wrea(mem_wrea), .o_mem_ada(mem_ada), .o_mem_dina(mem_dina),
    .i_mem_douta(mem_douta)
  );

  function automatic logic [7:0] init_byte(input logic [10:0] a);
    return 8'(int'(a) * 37 + 243);
  endfunction

  // Bypass-mode RAM: read data appears the cycle after the access.
  logic [7:0] ram    [0:2047];
  bit         ram_wr [0:2047];
  always @(posedge clk) begin
    if (mem_cea) begin
      mem_douta <= ram_wr[mem_ada] ? ram[mem_ada] : init_byte(mem_ada);
      if (mem_wrea) begin
        ram[mem_ada]    <= mem_dina;
        ram_wr[mem_ada] <= 1'b1;
      end
    end
  end

  int n_chk = 0, n_pass = 0, n_wrea = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Reference model: shadow memory plus what the next cycle's outputs should be.
  logic [7:0]  ref_mem [0:2047];
  bit          m_pend, m_cv, m_ack, m_err;
  logic [10:0] m_pend_addr;
  logic [7:0]  m_cd, m_rd;
  int          m_wins;

  bit          s_ack_exp, s_cea, s_cpu_valid, s_ld_ack, s_wait, s_ld_err;
  logic [7:0]  s_cpu_data, s_ld_rdata;
  logic [10:0] s_ada;

  task automatic model_reset();
    m_pend = 0; m_cv = 0; m_ack = 0; m_err = 0; m_pend_addr = '0;
    m_cd = '0; m_rd = '0; m_wins = 0; s_ack_exp = 0;
  endtask

  task automatic cycle();
    int win;                // 0 idle, 1 CPU, 2 loader
    bit ldw, defer, from_pend, block, exp_wr;
    logic [10:0] waddr;
    @(negedge clk);
    ldw = ld_req && !m_ack;
    win = 0; defer = 0; from_pend = 0; waddr = '0;
    if (m_pend) begin
      win = 1; waddr = m_pend_addr; from_pend = 1;
    end else if (ldw && m_wins >= STARVE) begin
      win = 2; waddr = ld_addr; defer = cpu_req;
    end else if (cpu_req) begin
      win = 1; waddr = cpu_addr;
    end else if (ldw) begin
      win = 2; waddr = ld_addr;
    end
    block  = WP_EN && ld_we && wp;
    exp_wr = (win == 2) && ld_we && !block;

    s_cea = mem_cea; s_cpu_valid = cpu_valid; s_ld_ack = ld_ack; s_wait = cpu_wait;
    s_ld_err = ld_err; s_cpu_data = cpu_data; s_ld_rdata = ld_rdata; s_ada = mem_ada;
    s_ack_exp = m_ack;
    chk("cpu_valid", 32'(cpu_valid), 32'(m_cv));
    chk("cpu_data", 32'(cpu_data), 32'(m_cd));
    chk("ld_ack", 32'(ld_ack), 32'(m_ack));
    chk("ld_rdata", 32'(ld_rdata), 32'(m_rd));
    chk("cpu_wait", 32'(cpu_wait), 32'(m_pend));
    chk("mem_cea", 32'(mem_cea), 32'(win != 0));
    chk("mem_wrea", 32'(mem_wrea), 32'(exp_wr));
    chk("ld_err", 32'(ld_err), 32'(m_err));
    if (win != 0) chk("mem_ada", 32'(mem_ada), 32'(waddr));
    if (exp_wr) chk("mem_dina", 32'(mem_dina), 32'(ld_wdata));
    if (mem_wrea === 1'b1) n_wrea++;

    @(posedge clk); #1;
    m_cv  = (win == 1);
    m_ack = (win == 2);
    if (win == 1) m_cd = ref_mem[waddr];
    if (win == 2) begin
      if (!ld_we)     m_rd = ref_mem[ld_addr];
      else if (block) m_err = 1;
      else            ref_mem[ld_addr] = ld_wdata;
    end
    if (win == 2 || !ld_req) m_wins = 0;
    else if (win == 1 && ldw && m_wins < STARVE) m_wins++;
    if (defer) begin
      m_pend = 1; m_pend_addr = cpu_addr;
    end else if (from_pend) begin
      m_pend = 0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cpu_wait"}, 32'(cpu_wait), 32'd0);
    chk({tag, "_cpu_valid"}, 32'(cpu_valid), 32'd0);
    chk({tag, "_cpu_data"}, 32'(cpu_data), 32'd0);
    chk({tag, "_ld_ack"}, 32'(ld_ack), 32'd0);
    chk({tag, "_ld_rdata"}, 32'(ld_rdata), 32'd0);
    chk({tag, "_ld_err"}, 32'(ld_err), 32'd0);
    chk({tag, "_mem_cea"}, 32'(mem_cea), 32'd0);
    chk({tag, "_mem_ocea"}, 32'(mem_ocea), 32'd1);
    chk({tag, "_mem_reseta"}, 32'(mem_reseta), 32'd0);
    chk({tag, "_mem_wrea"}, 32'(mem_wrea), 32'd0);
    chk({tag, "_mem_ada"}, 32'(mem_ada), 32'd0);
    chk({tag, "_mem_dina"}, 32'(mem_dina), 32'd0);
  endtask

  task automatic ld_txn(input bit we, input logic [10:0] a, input logic [7:0] d, input bit p);
    int n;
    n = 0;
    ld_we = we; ld_addr = a; ld_wdata = d; wp = p; ld_req = 1'b1;
    do begin
      cycle();
      n++;
    end while (!s_ack_exp && n < 20);
    chk("ld_txn_ack", 32'(s_ld_ack), 32'd1);
    ld_req = 1'b0;
    cycle();
  endtask

  initial begin
    int n0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = init_byte(11'(i));
    model_reset();
    rst_n = 1'b0; cpu_req = 0; cpu_addr = '0; ld_req = 0; ld_we = 0;
    ld_addr = '0; ld_wdata = '0; wp = 0;
    repeat (2) @(negedge clk);
    check_reset("por");
    @(posedge clk); #1 rst_n = 1'b1;

    // CPU read of address 0
    cpu_req = 1; cpu_addr = 11'h000; cycle();
    cpu_req = 0; cycle();
    chk("cpu_rd_valid", 32'(s_cpu_valid), 32'd1);
    chk("cpu_rd_data", 32'(s_cpu_data), 32'hF3);
    chk("cpu_rd_wait", 32'(s_wait), 32'd0);

    // Loader write then readback at the top address
    n0 = n_wrea;
    ld_txn(1'b1, 11'h7FF, 8'h5A, 1'b0);
    chk("ld_wr_wrea_once", 32'(n_wrea - n0), 32'd1);
    ld_txn(1'b0, 11'h7FF, 8'h00, 1'b0);
    chk("ld_rd_back", 32'(s_ld_rdata), 32'h5A);

    // Simultaneous requests with no starvation history: CPU first
    cpu_req = 1; cpu_addr = 11'h003; ld_req = 1; ld_we = 0; ld_addr = 11'h004;
    cycle();
    chk("same_cpu_ada", 32'(s_ada), 32'h003);
    cpu_req = 0; cycle();
    chk("same_cpu_valid", 32'(s_cpu_valid), 32'd1);
    chk("same_ld_ada", 32'(s_ada), 32'h004);
    cycle();
    chk("same_ld_ack", 32'(s_ld_ack), 32'd1);
    chk("same_ld_rdata", 32'(s_ld_rdata), 32'(init_byte(11'h004)));
    ld_req = 0; cycle();

    // Starvation: loader forced after eight CPU wins
    ld_req = 1; ld_we = 0; ld_addr = 11'h7FF;
    for (int k = 0; k < 11; k++) begin
      cpu_req  = (k <= 8);
      cpu_addr = 11'(k);
      if (k == 10) ld_req = 0;
      cycle();
      if (k == 8) chk("starve_ld_ada", 32'(s_ada), 32'h7FF);
      if (k == 9) begin
        chk("starve_ld_ack", 32'(s_ld_ack), 32'd1);
        chk("starve_wait", 32'(s_wait), 32'd1);
        chk("starve_rdata", 32'(s_ld_rdata), 32'h5A);
      end
      if (k == 10) begin
        chk("starve_cpu_valid", 32'(s_cpu_valid), 32'd1);
        chk("starve_cpu_data", 32'(s_cpu_data), 32'(init_byte(11'd8)));
        chk("starve_wait_end", 32'(s_wait), 32'd0);
      end
    end

    // Protected write attempt
    ld_txn(1'b1, 11'h010, 8'hFF, 1'b1);
    chk("wp_err", 32'(s_ld_err), 32'(WP_EN));
    ld_txn(1'b0, 11'h010, 8'h00, 1'b0);
    chk("wp_readback", 32'(s_ld_rdata), WP_EN ? 32'(init_byte(11'h010)) : 32'hFF);

    // Reset the cycle after a loader issue
    ld_we = 0; ld_addr = 11'h123; wp = 0; ld_req = 1;
    cycle();
    chk("rst_ld_issue", 32'(s_cea), 32'd1);
    rst_n = 1'b0; ld_req = 0;
    @(negedge clk);
    check_reset("mid");
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) cycle();
    cpu_req = 1; cpu_addr = 11'h005; cycle();
    cpu_req = 0; cycle();
    chk("post_rst_valid", 32'(s_cpu_valid), 32'd1);
    chk("post_rst_data", 32'(s_cpu_data), 32'(init_byte(11'h005)));

    // Random mixed traffic
    for (int c = 0; c < 3000; c++) begin
      if (s_ack_exp) begin
        ld_req = 0;
      end else if (!ld_req && $urandom_range(0, 99) < 40) begin
        ld_we    = 1'($urandom_range(0, 1));
        ld_addr  = 11'($urandom_range(0, 15));
        ld_wdata = 8'($urandom_range(0, 255));
        wp       = ($urandom_range(0, 7) == 0);
        ld_req   = 1;
      end
      cpu_req  = !m_pend && ($urandom_range(0, 99) < 75);
      cpu_addr = 11'($urandom_range(0, 15));
      cycle();
    end
    cpu_req = 0; ld_req = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/ext_rom_arbiter.md
Name: ext_rom_arbiter

Overview:
- Shares port A of the 2K x 8 dual-port block RAM that holds the extension ROM image between two requesters: the Z80 bus read path and the ESP-side image loader.
- CPU reads have priority and a fixed latency.
- The loader gets read/write slots through a req/ack handshake, with a starvation guarantee.
- Sits between the Z80 bus decoder / loader FSM and the RAM primitive wrapper.

Parameters:
- ADDR_W, 11, RAM address width (2048 bytes).
- DATA_W, 8, data width.
- STARVE_LIMIT, 8, consecutive CPU-won arbitrations, with a loader request pending, before the loader is forced a slot.

Ports:
- clk  in  1  system clock, also the RAM port-A clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  single-cycle read strobe.
- cpu_addr  in  ADDR_W  read address, valid with cpu_req.
- cpu_wait  out  1  high while a CPU read is deferred; drives Z80 WAIT.
- cpu_valid  out  1  one-cycle pulse, cpu_data valid.
- cpu_data  out  DATA_W  read data.
- ld_req  in  1  level request, held until ld_ack.
- ld_we  in  1  1 = write, 0 = read; stable while ld_req is high.
- ld_addr  in  ADDR_W  loader address.
- ld_wdata  in  DATA_W  loader write data.
- ld_ack  out  1  one-cycle completion pulse.
- ld_rdata  out  DATA_W  read data, valid with ld_ack.
- wp  in  1  write-protect request (used only with the optional feature).
- ld_err  out  1  sticky: write rejected by protection.
- mem_cea  out  1  RAM port-A clock enable.
- mem_ocea  out  1  RAM output clock enable.
- mem_reseta  out  1  RAM output reset.
- mem_wrea  out  1  RAM write enable.
- mem_ada  out  ADDR_W  RAM address.
- mem_dina  out  DATA_W  RAM write data.
- mem_douta  in  DATA_W  RAM read data, bypass mode, valid one cycle after issue.

Behaviour:
- Reset values: all outputs 0, except mem_ocea=1. Counters and pending regs cleared. Reset mid-transaction drops it; no ack or valid is generated afterwards.
- Each cycle the arbiter issues at most one access (issue cycle N). Requesters, in priority order:
  1. pending CPU read (deferred from an earlier cycle),
  2. new cpu_req,
  3. ld_req, if no loader access is in flight.
- Starvation override:
  - starve_cnt increments on each cycle a CPU access is issued while ld_req is high and not yet issued.
  - When starve_cnt==STARVE_LIMIT, the loader wins the next arbitration even over a CPU request.
  - That CPU request is latched into the pending register and cpu_wait goes high from the cycle after the strobe until its issue.
  - starve_cnt clears on any loader issue or when ld_req is low.
- Issue cycle N: mem_cea=1, mem_ada=selected address, mem_wrea=1 only for a permitted loader write, mem_dina=ld_wdata. Idle cycles: mem_cea=0, mem_wrea=0.
- Completion at N+1:
  - CPU read: cpu_valid=1, cpu_data=mem_douta.
  - Loader: ld_ack=1; ld_rdata=mem_douta for a read, unchanged for a write.
- CPU latency: exactly 1 cycle when not deferred; 2 cycles when deferred by a forced loader slot.
- Loader in-flight tracking:
  - ld_inflight is set on issue and cleared with ld_ack.
  - ld_req sampled high while ld_inflight=1 is not re-issued.
  - The requester drops ld_req in the cycle after ld_ack; otherwise a new transaction starts.
- cpu_req while cpu_wait=1: ignored; the Z80 cannot strobe while waited.
- cpu_req and a forced loader slot in the same cycle: loader issues, CPU is deferred. Never two accesses in one cycle.
- mem_reseta is tied 0 after reset.

Optional Feature:
- Macro: EXT_ROM_WP_EN.
- Defined:
  - wp=1 blocks loader writes: the slot is still consumed, mem_wrea stays 0, ld_ack still pulses, and ld_err is set (sticky until reset).
  - Loader reads are unaffected.
- Undefined: the wp input is ignored and ld_err stays 0.

Decomposition:
- Package ext_rom_pkg: ADDR_W and DATA_W constants, and the owner enum OWN_NONE / OWN_CPU / OWN_LD_RD / OWN_LD_WR used for the in-flight register.
- Optional sub-module ext_rom_starve_ctr, holding the saturating starvation counter and force flag. Everything else stays flat.

Test Plan:
- CPU read: cpu_req with cpu_addr=0x000 -> cpu_valid 1 cycle later, cpu_data=0xF3; cpu_wait stays 0.
- Loader write then read: write 0x5A to 0x7FF, then read 0x7FF -> two ld_ack pulses, ld_rdata=0x5A; mem_wrea high exactly one cycle.
- Starvation: ld_req held with cpu_req every cycle -> loader issues after 8 CPU issues; the concurrent CPU read gets cpu_wait=1 for 1 cycle and is served at latency 2 with correct data.
- Same cycle, no starvation: cpu_req and ld_req both rise with starve_cnt=0 -> CPU issues first, loader issues next cycle; acks land in order.
- EXT_ROM_WP_EN with wp=1: loader write 0xFF to 0x010 -> ld_ack pulses, ld_err=1, and a readback returns the original byte.
- Reset mid-transaction: rst_n low in the cycle after loader issue -> no ld_ack; all outputs at reset values; normal operation after release.
